// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared FSM states, line constants and byte selection for the ALU result serializer (MTM_ALU_SER_PARITY_EN adds the PARITY state)
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FLAG,
    S_DATA,
`ifdef MTM_ALU_SER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic BIT_START = 1'b0;
  localparam logic BIT_STOP  = 1'b1;
  localparam logic BIT_IDLE  = 1'b1;
  localparam logic FLAG_DATA = 1'b0;
  localparam logic FLAG_CTL  = 1'b1;
  localparam int DATA_BYTES  = 4;
  localparam int CTL_ERR_BIT = 7;
  localparam logic [2:0] CTL_IDX = 3'(DATA_BYTES);

  // Byte indices 0..3 walk the result word MSB first; index DATA_BYTES is the status byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] c, input logic [7:0] ctl, input logic [2:0] idx);
    return idx == 3'd0 ? c[31:24] :
           idx == 3'd1 ? c[23:16] :
           idx == 3'd2 ? c[15:8]  :
           idx == 3'd3 ? c[7:0]   : ctl;
  endfunction

endpackage

// File: rtl/mtm_alu_bit_timer.sv
// mtm_alu_bit_timer: counts BIT_CYCLES clocks per serial bit and pulses tick in the last cycle of each bit
module mtm_alu_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = run && cnt == 8'(BIT_CYCLES - 1);

  // Free-running while a packet is on the line; held at zero when idle so each packet starts a fresh bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!run || tick) ? '0 : cnt + 8'd1;

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: frames a 32-bit ALU result and status byte onto a UART-like line; define MTM_ALU_SER_PARITY_EN for an even-parity bit per frame
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] C,
  input  logic [7:0]  CTL,
  input  logic        valid,
  output logic        ready,
  output logic        sout
);

  state_t      state, state_n;
  logic        sout_n;
  logic        tick;
  logic [2:0]  bit_idx, bit_n;
  logic [2:0]  byte_idx, byte_n;
  logic [7:0]  sh, sh_n;
  logic [31:0] cap_c, c_n;
  logic [7:0]  cap_ctl, ctl_n;
  logic [7:0]  cur;

  assign ready = state == S_IDLE;
  assign cur   = byte_sel(cap_c, cap_ctl, byte_idx);

  mtm_alu_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state != S_IDLE),
    .tick (tick)
  );

  // State, line and captured packet registers; reset abandons any packet and idles the line high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      sout     <= BIT_IDLE;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      cap_c    <= '0;
      cap_ctl  <= '0;
    end else begin
      state    <= state_n;
      sout     <= sout_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      sh       <= sh_n;
      cap_c    <= c_n;
      cap_ctl  <= ctl_n;
    end

  // Next state plus the value the line takes in that state, so sout leaves a flop aligned with the state.
  always_comb begin
    state_n = state;
    sout_n  = sout;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    sh_n    = sh;
    c_n     = cap_c;
    ctl_n   = cap_ctl;
    case (state)
      S_IDLE: begin
        sout_n = BIT_IDLE;
        if (valid) begin
          state_n = S_START;
          sout_n  = BIT_START;
          c_n     = C;
          ctl_n   = CTL;
          byte_n  = CTL[CTL_ERR_BIT] ? CTL_IDX : 3'd0;
        end
      end
      S_START:
        if (tick) begin
          state_n = S_FLAG;
          sout_n  = byte_idx == CTL_IDX ? FLAG_CTL : FLAG_DATA;
        end
      S_FLAG:
        if (tick) begin
          state_n = S_DATA;
          sout_n  = cur[7];
          sh_n    = {cur[6:0], 1'b0};
          bit_n   = '0;
        end
      S_DATA:
        if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef MTM_ALU_SER_PARITY_EN
            state_n = S_PARITY;
            sout_n  = ^cur;
`else
            state_n = S_STOP;
            sout_n  = BIT_STOP;
`endif
          end else begin
            bit_n  = bit_idx + 3'd1;
            sout_n = sh[7];
            sh_n   = {sh[6:0], 1'b0};
          end
        end
`ifdef MTM_ALU_SER_PARITY_EN
      S_PARITY:
        if (tick) begin
          state_n = S_STOP;
          sout_n  = BIT_STOP;
        end
`endif
      S_STOP:
        if (tick) begin
          state_n = byte_idx == CTL_IDX ? S_IDLE : S_START;
          sout_n  = byte_idx == CTL_IDX ? BIT_IDLE : BIT_START;
          byte_n  = byte_idx == CTL_IDX ? byte_idx : byte_idx + 3'd1;
        end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb_mtm_alu_serializer: directed vectors checked against a per-cycle packet model for BIT_CYCLES=1 and BIT_CYCLES=4
module tb_mtm_alu_serializer;

`ifdef MTM_ALU_SER_PARITY_EN
  localparam int FB = 12;
  localparam logic [59:0] A_EXP = 60'b0_0_00010010_0_1_0_0_00110100_1_1_0_0_01010110_0_1_0_0_01111000_0_1_0_1_00001011_1_1;
  localparam logic [59:0] B_EXP = 60'b0_1_10010011_0_1;
  localparam logic [59:0] D_EXP = 60'b0_0_00000000_0_1_0_0_00000000_0_1_0_0_00000000_0_1_0_0_00000001_1_1_0_1_00100000_1_1;
`else
  localparam int FB = 11;
  localparam logic [59:0] A_EXP = 60'b0_0_00010010_1_0_0_00110100_1_0_0_01010110_1_0_0_01111000_1_0_1_00001011_1;
  localparam logic [59:0] B_EXP = 60'b0_1_10010011_1;
  localparam logic [59:0] D_EXP = 60'b0_0_00000000_1_0_0_00000000_1_0_0_00000000_1_0_0_00000001_1_0_1_00100000_1;
`endif

  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] c0 = 0, c1 = 0;
  logic [7:0]  ctl0 = 0, ctl1 = 0;
  logic        v0 = 0, v1 = 0;
  logic        r0, r1, s0, s1;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mtm_alu_serializer #(.BIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .C(c0), .CTL(ctl0), .valid(v0), .ready(r0), .sout(s0)
  );

  mtm_alu_serializer #(.BIT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .C(c1), .CTL(ctl1), .valid(v1), .ready(r1), .sout(s1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Line level at packet bit k, straight from the frame definition.
  function automatic logic pkt_bit(input logic [31:0] c, input logic [7:0] ctl, input int k);
    int f = k / FB;
    int b = k % FB;
    logic fl = ctl[7] || f == 4;
    logic [7:0] by = fl ? ctl : 8'(c >> (24 - 8 * f));
    if (b == 0) return 1'b0;
    if (b == 1) return fl;
    if (b < 10) return by[9 - b];
    if (b == FB - 1) return 1'b1;
    return ^by;
  endfunction

  logic [31:0] mc0 = 0, mc1 = 0;
  logic [7:0]  mctl0 = 0, mctl1 = 0;
  int          pos0 = 0, len0 = 0, pos1 = 0, len1 = 0;

  // Model: a packet of len cycles runs from the cycle after acceptance; idle when len is zero.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) len0 <= 0;
    else if (len0 == 0) begin
      if (v0) begin
        mc0 <= c0; mctl0 <= ctl0; pos0 <= 0;
        len0 <= (ctl0[7] ? 1 : 5) * FB;
      end
    end else begin
      pos0 <= pos0 + 1;
      if (pos0 + 1 == len0) len0 <= 0;
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) len1 <= 0;
    else if (len1 == 0) begin
      if (v1) begin
        mc1 <= c1; mctl1 <= ctl1; pos1 <= 0;
        len1 <= (ctl1[7] ? 1 : 5) * FB * 4;
      end
    end else begin
      pos1 <= pos1 + 1;
      if (pos1 + 1 == len1) len1 <= 0;
    end

  always @(negedge clk) begin
    chk("sout_bc1", s0, len0 != 0 ? pkt_bit(mc0, mctl0, pos0) : 1'b1);
    chk("ready_bc1", r0, len0 == 0);
    chk("sout_bc4", s1, len1 != 0 ? pkt_bit(mc1, mctl1, pos1 / 4) : 1'b1);
    chk("ready_bc4", r1, len1 == 0);
  end

  task automatic run_pkt(input logic [31:0] c, input logic [7:0] ctl, input int poke,
                         output logic [59:0] bits, output int low);
    bits = '0;
    low = 0;
    c0 = c; ctl0 = ctl; v0 = 1;
    @(posedge clk);
    #1 v0 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (low == poke) begin
        v0 = 1; c0 = 32'hAAAAAAAA;
      end else v0 = 0;
      if (r0) break;
      bits = {bits[58:0], s0};
      low++;
    end
    v0 = 0;
  endtask

  initial begin
    logic [59:0] bits;
    int low, z;
    logic seen1;
    repeat (2) @(negedge clk);
    chk("reset_sout", s0, 1'b1);
    chk("reset_ready", r0, 1'b1);
    chk("reset_sout4", s1, 1'b1);
    chk("reset_ready4", r1, 1'b1);
    rst_n = 1;
    @(negedge clk);

    run_pkt(32'h12345678, 8'h0B, -1, bits, low);
    chk("A_ready_low", low, 5 * FB);
    chk("A_bits", bits, A_EXP);

    run_pkt(32'hFFFFFFFF, 8'h93, -1, bits, low);
    chk("B_ready_low", low, FB);
    chk("B_bits", bits, B_EXP);

    run_pkt(32'h12345678, 8'h0B, 20, bits, low);
    chk("C_ready_low", low, 5 * FB);
    chk("C_bits", bits, A_EXP);
    low = 0;
    repeat (15) begin
      @(negedge clk);
      if (!r0) low++;
    end
    chk("C_no_second", low, 0);

    c0 = 32'h12345678; ctl0 = 8'h0B; v0 = 1;
    @(posedge clk);
    #1 v0 = 0;
    repeat (21) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("D_reset_sout", s0, 1'b1);
    chk("D_reset_ready", r0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_pkt(32'h00000001, 8'h20, -1, bits, low);
    chk("D_ready_low", low, 5 * FB);
    chk("D_bits", bits, D_EXP);

    c1 = 32'h0; ctl1 = 8'h10; v1 = 1;
    @(posedge clk);
    #1 v1 = 0;
    low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (r1) break;
      low++;
    end
    chk("E_ready_low", low, 5 * FB * 4);
    c1 = 32'h0; ctl1 = 8'h90; v1 = 1;
    @(posedge clk);
    #1 v1 = 0;
    low = 0; z = 0; seen1 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (r1) break;
      low++;
      if (s1) seen1 = 1;
      else if (!seen1) z++;
    end
    chk("E_start_cycles", z, 4);
    chk("E2_ready_low", low, FB * 4);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
